// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared types, defaults and pulse-width helpers for the servo controller
package servo_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_UPDATE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    typedef logic [11:0] pw_t;

    localparam int DEF_MIN_US    = 1000;
    localparam int DEF_MAX_US    = 2000;
    localparam int DEF_PERIOD_US = 20000;

    function automatic pw_t clamp_pw(input pw_t pw, input pw_t lo, input pw_t hi);
        if (pw < lo) return lo;
        if (pw > hi) return hi;
        return pw;
    endfunction

    // Moves cur toward tgt by at most step; both stay inside [MIN, MAX], so no wrap is possible.
    function automatic pw_t ramp_step(input pw_t cur, input pw_t tgt, input pw_t step);
        pw_t diff;
        if (step == '0) return tgt;
        if (tgt > cur) begin
            diff = tgt - cur;
            return (diff > step) ? pw_t'(cur + step) : tgt;
        end
        diff = cur - tgt;
        return (diff > step) ? pw_t'(cur - step) : tgt;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// rtl/us_tick_gen.sv - one-cycle strobe every microsecond derived from clk
module us_tick_gen #(
    parameter int CLK_HZ = 100000000
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);
    localparam int DIV = CLK_HZ / 1000000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/multi_servo_controller.sv
// rtl/multi_servo_controller.sv - N-channel servo PWM generator with per-frame slew-limited targets
module multi_servo_controller
    import servo_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CLK_HZ    = 100000000,
    parameter int PERIOD_US = DEF_PERIOD_US,
    parameter int MIN_US    = DEF_MIN_US,
    parameter int MAX_US    = DEF_MAX_US,
    parameter int STEP_US   = 10,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [11:0]       cmd_pw,
    output logic [NUM_CH-1:0] servo_out,
    output logic              frame_start,
    output logic              busy,
    output logic              cmd_err
);
    localparam int FW = $clog2(PERIOD_US + 1);
    localparam pw_t PW_MIN  = pw_t'(MIN_US);
    localparam pw_t PW_MAX  = pw_t'(MAX_US);
    localparam pw_t PW_MID  = pw_t'((MIN_US + MAX_US) / 2);
    localparam pw_t PW_STEP = pw_t'(STEP_US);
    localparam logic [FW-1:0]   FRAME_LAST = FW'(PERIOD_US - 1);
    localparam logic [CH_W-1:0] CH_LAST    = CH_W'(NUM_CH - 1);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("NUM_CH must be 1..16");
    end
    if (NUM_CH > CLK_HZ / 1000000) begin : g_bad_update_window
        $error("NUM_CH exceeds clk cycles per microsecond");
    end
    if (MIN_US >= MAX_US) begin : g_bad_range
        $error("MIN_US must be below MAX_US");
    end
    if (MAX_US >= PERIOD_US) begin : g_bad_period
        $error("MAX_US must be below PERIOD_US");
    end

    logic              w_tick;
    logic              w_wrap;
    logic              w_accept;
    logic              w_cmd_bad;
    logic              w_out_en;
    logic              w_busy;
    logic              w_in_update;
    logic              w_in_wait;
    logic              w_ready_next;
    pw_t               w_cmd_pw;
    state_t            w_state_next;

    state_t            r_state;
    logic [FW-1:0]     r_frame_us;
    logic [CH_W-1:0]   r_idx;
    pw_t               r_cur [NUM_CH];
    pw_t               r_tgt [NUM_CH];
    logic              r_ready;
    logic              r_frame_start;
    logic              r_busy;
    logic              r_cmd_err;
    logic              r_out_en;
    logic [NUM_CH-1:0] r_servo;

    us_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .tick   (w_tick)
    );

    assign w_wrap    = w_tick && (r_frame_us == FRAME_LAST);
    assign w_accept  = cmd_valid && r_ready;
    assign w_cmd_bad = {{(32-CH_W){1'b0}}, cmd_ch} >= 32'(NUM_CH);
    assign w_cmd_pw  = clamp_pw(cmd_pw, PW_MIN, PW_MAX);
    // Output only starts on a frame boundary, so a mid-frame enable never yields a runt pulse.
    assign w_out_en  = enable && (r_out_en || w_wrap);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_frame_us <= '0;
        end else if (w_tick) begin
            r_frame_us <= (r_frame_us == FRAME_LAST) ? '0 : r_frame_us + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_RUN;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= (w_in_update && r_idx != CH_LAST) ? r_idx + 1'b1 : '0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:    if (w_wrap) w_state_next = ST_UPDATE;
            ST_UPDATE: if (r_idx == CH_LAST) w_state_next = ST_WAIT;
            ST_WAIT:   if (w_tick) w_state_next = ST_RUN;
            default:   w_state_next = ST_RUN;
        endcase
    end

    always_comb begin
        w_in_update  = (r_state == ST_UPDATE);
        w_in_wait    = (r_state == ST_WAIT);
        w_ready_next = (w_state_next == ST_RUN);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cur[i] <= PW_MID;
                r_tgt[i] <= PW_MID;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_accept && !w_cmd_bad && cmd_ch == CH_W'(i)) r_tgt[i] <= w_cmd_pw;
                if (w_in_update && r_idx == CH_W'(i)) r_cur[i] <= ramp_step(r_cur[i], r_tgt[i], PW_STEP);
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_cur[i] != r_tgt[i]) w_busy = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ready       <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
            r_cmd_err     <= 1'b0;
            r_out_en      <= 1'b1;
            r_servo       <= '0;
        end else begin
            r_ready       <= w_ready_next;
            r_frame_start <= w_wrap;
            r_cmd_err     <= w_accept && w_cmd_bad;
            r_out_en      <= w_out_en;
            if (w_in_wait) r_busy <= w_busy;
            for (int i = 0; i < NUM_CH; i++) begin
                r_servo[i] <= w_out_en && (32'(r_frame_us) < 32'(r_cur[i]));
            end
        end
    end

    assign cmd_ready   = r_ready;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;
    assign cmd_err     = r_cmd_err;
    assign servo_out   = r_servo;

endmodule

// File: tb/tb_multi_servo_controller.sv
// tb/tb_multi_servo_controller.sv - directed self-checking bench for multi_servo_controller
module tb_multi_servo_controller;
    localparam int NUM_CH    = 3;
    localparam int CLK_HZ    = 4000000;
    localparam int PERIOD_US = 200;
    localparam int MIN_US    = 50;
    localparam int MAX_US    = 150;
    localparam int STEP_US   = 10;
    localparam int DIV       = 4;
    localparam int FRAME_CYC = PERIOD_US * DIV;

    logic              clk       = 1'b0;
    logic              resetn    = 1'b0;
    logic              enable    = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_ch    = '0;
    logic [11:0]       cmd_pw    = '0;
    logic [NUM_CH-1:0] servo_out;
    logic              frame_start;
    logic              busy;
    logic              cmd_err;

    int   total = 0;
    int   bad   = 0;
    int   width [NUM_CH];
    int   cmd_wait;
    logic err_now;
    logic err_next;

    multi_servo_controller #(
        .NUM_CH    (NUM_CH),
        .CLK_HZ    (CLK_HZ),
        .PERIOD_US (PERIOD_US),
        .MIN_US    (MIN_US),
        .MAX_US    (MAX_US),
        .STEP_US   (STEP_US)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_ch      (cmd_ch),
        .cmd_pw      (cmd_pw),
        .servo_out   (servo_out),
        .frame_start (frame_start),
        .busy        (busy),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fs();
        int n = 0;
        while (frame_start !== 1'b1 && n < 2 * FRAME_CYC) begin
            step();
            n++;
        end
        total++;
        if (frame_start !== 1'b1) begin
            bad++;
            $display("FAIL wait_fs: frame_start=%b after %0d cycles, need 1", frame_start, n);
        end
    endtask

    // Counts high cycles per channel over one frame, starting at a frame_start cycle.
    task automatic measure_frame();
        wait_fs();
        for (int c = 0; c < NUM_CH; c++) width[c] = 0;
        for (int t = 0; t < FRAME_CYC; t++) begin
            for (int c = 0; c < NUM_CH; c++) if (servo_out[c]) width[c]++;
            step();
        end
    endtask

    task automatic send_cmd(input logic [1:0] ch, input logic [11:0] pw);
        cmd_ch    = ch;
        cmd_pw    = pw;
        cmd_valid = 1'b1;
        cmd_wait  = 0;
        while (cmd_ready !== 1'b1 && cmd_wait < 50) begin
            step();
            cmd_wait++;
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_cmd_ready: got=%b need=1", cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
        err_now   = cmd_err;
        step();
        err_next  = cmd_err;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) step();
        total++;
        if (servo_out !== '0 || frame_start !== 1'b0 || cmd_err !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: servo=%b fs=%b err=%b busy=%b ready=%b need all 0",
                     servo_out, frame_start, cmd_err, busy, cmd_ready);
        end
        resetn = 1'b1;
        step();
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset: got=%b need=1", cmd_ready);
        end
    endtask

    task automatic test_idle();
        measure_frame();
        for (int c = 0; c < NUM_CH; c++) begin
            total++;
            if (width[c] != 100 * DIV) begin
                bad++;
                $display("FAIL idle_width ch%0d: got=%0d need=%0d", c, width[c], 100 * DIV);
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_busy: got=%b need=0", busy);
        end
        step();
        total++;
        if (frame_start !== 1'b0) begin
            bad++;
            $display("FAIL frame_start_width: got=%b need=0", frame_start);
        end
    endtask

    task automatic test_ramp();
        int exp_w;
        send_cmd(2'd1, 12'd150);
        total++;
        if (err_now !== 1'b0) begin
            bad++;
            $display("FAIL ramp_cmd_err: got=%b need=0", err_now);
        end
        for (int k = 1; k <= 6; k++) begin
            measure_frame();
            exp_w = ((100 + 10 * k > 150) ? 150 : 100 + 10 * k) * DIV;
            total++;
            if (width[1] != exp_w || width[0] != 100 * DIV || width[2] != 100 * DIV) begin
                bad++;
                $display("FAIL ramp_frame%0d: got=%0d/%0d/%0d need=%0d/%0d/%0d", k,
                         width[0], width[1], width[2], 100 * DIV, exp_w, 100 * DIV);
            end
            total++;
            if (busy !== (k < 5)) begin
                bad++;
                $display("FAIL ramp_busy%0d: got=%b need=%b", k, busy, (k < 5));
            end
        end
    endtask

    task automatic test_clamp();
        int exp_w;
        send_cmd(2'd0, 12'd30);
        for (int k = 1; k <= 6; k++) begin
            measure_frame();
            exp_w = ((100 - 10 * k < 50) ? 50 : 100 - 10 * k) * DIV;
            total++;
            if (width[0] != exp_w || busy !== (k < 5)) begin
                bad++;
                $display("FAIL clamp_low%0d: width=%0d busy=%b need width=%0d busy=%b", k, width[0], busy, exp_w, (k < 5));
            end
        end
        send_cmd(2'd0, 12'd3000);
        for (int k = 1; k <= 11; k++) begin
            measure_frame();
            exp_w = ((50 + 10 * k > 150) ? 150 : 50 + 10 * k) * DIV;
            total++;
            if (width[0] != exp_w || busy !== (k < 10)) begin
                bad++;
                $display("FAIL clamp_high%0d: width=%0d busy=%b need width=%0d busy=%b", k, width[0], busy, exp_w, (k < 10));
            end
        end
    endtask

    task automatic test_bad_channel();
        send_cmd(2'd3, 12'd150);
        total++;
        if (err_now !== 1'b1 || err_next !== 1'b0) begin
            bad++;
            $display("FAIL cmd_err_pulse: got=%b,%b need=1,0", err_now, err_next);
        end
        measure_frame();
        total++;
        if (width[0] != 150 * DIV || width[1] != 150 * DIV || width[2] != 100 * DIV || busy !== 1'b0) begin
            bad++;
            $display("FAIL bad_ch_no_change: got=%0d/%0d/%0d busy=%b need=%0d/%0d/%0d busy=0",
                     width[0], width[1], width[2], busy, 150 * DIV, 150 * DIV, 100 * DIV);
        end
    endtask

    task automatic test_hold_across_update();
        wait_fs();
        send_cmd(2'd2, 12'd50);
        total++;
        if (cmd_wait != NUM_CH + 1) begin
            bad++;
            $display("FAIL hold_ready_low: got=%0d cycles need=%0d", cmd_wait, NUM_CH + 1);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL hold_old_target: busy got=%b need=0", busy);
        end
        measure_frame();
        total++;
        if (width[2] != 90 * DIV || width[0] != 150 * DIV || busy !== 1'b1) begin
            bad++;
            $display("FAIL hold_applied: ch2=%0d ch0=%0d busy=%b need ch2=%0d ch0=%0d busy=1",
                     width[2], width[0], busy, 90 * DIV, 150 * DIV);
        end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        measure_frame();
        total++;
        if (width[0] != 0 || width[1] != 0 || width[2] != 0) begin
            bad++;
            $display("FAIL disabled_frame: got=%0d/%0d/%0d need=0/0/0", width[0], width[1], width[2]);
        end
        wait_fs();
        repeat (100) step();
        enable = 1'b1;
        for (int c = 0; c < NUM_CH; c++) width[c] = 0;
        for (int t = 0; t < FRAME_CYC - 100; t++) begin
            for (int c = 0; c < NUM_CH; c++) if (servo_out[c]) width[c]++;
            step();
        end
        total++;
        if (width[0] != 0 || width[1] != 0 || width[2] != 0) begin
            bad++;
            $display("FAIL enable_mid_frame: got=%0d/%0d/%0d need=0/0/0", width[0], width[1], width[2]);
        end
        measure_frame();
        total++;
        if (width[0] != 150 * DIV || width[1] != 150 * DIV || width[2] != 60 * DIV) begin
            bad++;
            $display("FAIL enable_resume: got=%0d/%0d/%0d need=%0d/%0d/%0d",
                     width[0], width[1], width[2], 150 * DIV, 150 * DIV, 60 * DIV);
        end
    endtask

    task automatic test_reset_mid_update();
        int n;
        wait_fs();
        step();
        step();
        resetn = 1'b0;
        #1;
        total++;
        if (servo_out !== '0 || cmd_ready !== 1'b0 || busy !== 1'b0 || frame_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_update: servo=%b ready=%b busy=%b fs=%b need all 0",
                     servo_out, cmd_ready, busy, frame_start);
        end
        repeat (2) step();
        resetn = 1'b1;
        n = 0;
        while (frame_start !== 1'b1 && n < 2 * FRAME_CYC) begin
            step();
            n++;
        end
        total++;
        if (n != FRAME_CYC) begin
            bad++;
            $display("FAIL frame_restart: first frame_start after %0d cycles need %0d", n, FRAME_CYC);
        end
        measure_frame();
        for (int c = 0; c < NUM_CH; c++) begin
            total++;
            if (width[c] != 100 * DIV) begin
                bad++;
                $display("FAIL post_reset_width ch%0d: got=%0d need=%0d", c, width[c], 100 * DIV);
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_busy: got=%b need=0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_ramp();
        test_clamp();
        test_bad_channel();
        test_hold_across_update();
        test_enable();
        test_reset_mid_update();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
